// File: rtl/obs_mult_pkg.sv
// Shared constants and FSM state type for the split carry-less multiplier.
package obs_mult_pkg;

   localparam int OBS_N = 26;
   localparam int OBS_H = 13;
   localparam int OBS_P = 25;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

endpackage

// File: rtl/clmul_bitserial_13bit.sv
// One MSB-first shift-XOR accumulator: a GF(2) product of an H-bit
// multiplicand and a multiplier fed one bit per step.
module clmul_bitserial_13bit
   import obs_mult_pkg::*;
#(
   parameter int H = OBS_H,
   parameter int P = 2*H-1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clear,
   input  logic         i_step,
   input  logic [H-1:0] i_mcand,
   input  logic         i_mbit,
   output logic [P-1:0] o_acc
);

   logic [P-1:0] r_acc;
   logic [P-1:0] w_addend;

   assign w_addend = i_mbit ? {{(P-H){1'b0}}, i_mcand} : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_step) begin
         r_acc <= (r_acc << 1) ^ w_addend;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/obs_split_mult_26bit.sv
// Even/odd split of two N-bit GF(2) operands into four bit-serial
// half-width carry-less products, with a valid/ready handshake.
module obs_split_mult_26bit
   import obs_mult_pkg::*;
#(
   parameter int N = OBS_N,
   parameter int H = N/2,
   parameter int P = 2*H-1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [P-1:0] p_ee,
   output logic [P-1:0] p_eo,
   output logic [P-1:0] p_oe,
   output logic [P-1:0] p_oo
);

   localparam int CW = (H > 1) ? $clog2(H) : 1;
   localparam logic [CW-1:0] CNT_TOP = CW'(H-1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_in_ready;
   logic          r_out_valid;
   logic [H-1:0]  r_ae, r_ao, r_be, r_bo;

   logic [H-1:0]  w_ae, w_ao, w_be, w_bo;
   logic          w_accept;
   logic          w_step;
   logic          w_be_bit;
   logic          w_bo_bit;

   for (genvar j = 0; j < H; j++) begin : g_split
      assign w_ae[j] = a_in[2*j];
      assign w_ao[j] = a_in[2*j+1];
      assign w_be[j] = b_in[2*j];
      assign w_bo[j] = b_in[2*j+1];
   end

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_step   = (r_state == BUSY);
   assign w_be_bit = r_be[r_cnt];
   assign w_bo_bit = r_bo[r_cnt];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_ae        <= '0;
         r_ao        <= '0;
         r_be        <= '0;
         r_bo        <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_ae       <= w_ae;
                  r_ao       <= w_ao;
                  r_be       <= w_be;
                  r_bo       <= w_bo;
                  r_cnt      <= CNT_TOP;
                  r_in_ready <= 1'b0;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               if (r_cnt == '0) begin
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            DONE: begin
               // A new pair is only taken once back in IDLE, never here
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   clmul_bitserial_13bit #(.H(H), .P(P)) u_ee (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_accept),
      .i_step  (w_step),
      .i_mcand (r_ae),
      .i_mbit  (w_be_bit),
      .o_acc   (p_ee)
   );

   clmul_bitserial_13bit #(.H(H), .P(P)) u_eo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_accept),
      .i_step  (w_step),
      .i_mcand (r_ae),
      .i_mbit  (w_bo_bit),
      .o_acc   (p_eo)
   );

   clmul_bitserial_13bit #(.H(H), .P(P)) u_oe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_accept),
      .i_step  (w_step),
      .i_mcand (r_ao),
      .i_mbit  (w_be_bit),
      .o_acc   (p_oe)
   );

   clmul_bitserial_13bit #(.H(H), .P(P)) u_oo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_accept),
      .i_step  (w_step),
      .i_mcand (r_ao),
      .i_mbit  (w_bo_bit),
      .o_acc   (p_oo)
   );

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;

endmodule
